serial_link_scheduler: RTL and testbench

Shares one serial position transmitter (SCL/SDA frame engine) among NUM_REQ position sources. Runs round-robin arbitration and a valid/ready handshake per requester, latches the granted 10-bit word, and launches exactly one transmit frame. Tracks frame completion with a timeout, and enforces a minimum idle gap between frames. Sits between the position-generating blocks and the serial output engine.

---
 rtl/serial_link_if.sv | 26 ++
 rtl/serial_link_scheduler.sv | 136 +++++++++++++
 tb/tb_serial_link_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_link_if.sv
// Handshake bundle between position requesters, the link scheduler and the serial frame engine.
interface serial_link_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 10
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic [ID_W-1:0]           tx_id;
  logic                      tx_start;
  logic                      tx_busy;
  logic                      tx_done;

  modport master (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ready, tx_data, tx_id, tx_start
  );

  modport slave (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ready, tx_data, tx_id, tx_start
  );
endinterface

// File: rtl/serial_link_scheduler.sv
// Round-robin scheduler sharing one serial position transmitter among NUM_REQ sources,
// with frame timeout supervision and an enforced idle gap between frames.
module serial_link_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 10,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  serial_link_if.slave  link,
  output logic          link_idle,
  output logic          timeout_err,
  output logic [15:0]   frame_count
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic [ID_W-1:0]    tx_id_q;
  logic               tx_start_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [DATA_W-1:0]  grant_word;
  logic [NUM_REQ-1:0] ready_c;
  logic               accept, start_d, tmo_err_d, done_d, gap_load;
  logic               tmo_hit, gap_last;

  assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign gap_last = (gap_cnt_q <= GAP_W'(1));

  assign link.req_ready = ready_c;
  assign link.tx_data   = tx_data_q;
  assign link.tx_id     = tx_id_q;
  assign link.tx_start  = tx_start_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    grant_word = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_any && link.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == grant_idx) grant_word = link.req_data[k*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant_any) state_d = LAUNCH;
      LAUNCH:    if (!link.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (link.tx_done || tmo_hit) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output/control decode; ready is held low while reset is asserted
  always_comb begin
    ready_c   = '0;
    accept    = 1'b0;
    start_d   = 1'b0;
    tmo_err_d = 1'b0;
    done_d    = 1'b0;
    gap_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && !reset) begin
          accept  = 1'b1;
          ready_c = NUM_REQ'(1) << grant_idx;
        end
      end
      LAUNCH:    start_d = !link.tx_busy;
      WAIT_DONE: begin
        done_d    = link.tx_done;
        tmo_err_d = !link.tx_done && tmo_hit;
        gap_load  = (link.tx_done || tmo_hit) && (GAP_CYCLES != 0);
      end
      GAP:       ;
      default:   ;
    endcase
  end

  // Registered datapath and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      tx_data_q   <= '0;
      tx_id_q     <= '0;
      tx_start_q  <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
      link_idle   <= 1'b1;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      tx_start_q  <= start_d;
      timeout_err <= tmo_err_d;
      link_idle   <= (state_d == IDLE);
      if (accept) begin
        tx_data_q <= grant_word;
        tx_id_q   <= grant_idx;
        rr_ptr_q  <= ID_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
      end
      if (start_d)                 tmo_cnt_q <= '0;
      else if (state_q == WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (done_d) frame_count <= frame_count + 16'd1;
      if (gap_load)            gap_cnt_q <= GAP_W'(GAP_CYCLES);
      else if (state_q == GAP) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end
endmodule

// File: tb/tb_serial_link_scheduler.sv
// Directed bench for serial_link_scheduler: default instance plus a zero-gap instance.
module tb_serial_link_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic        idle_a, terr_a, idle_z, terr_z;
  logic [15:0] fc_a, fc_z;

  serial_link_if #(.NUM_REQ(4), .DATA_W(10)) if_a ();
  serial_link_if #(.NUM_REQ(4), .DATA_W(10)) if_z ();

  serial_link_scheduler #(.NUM_REQ(4), .DATA_W(10), .GAP_CYCLES(100), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .link(if_a.slave),
    .link_idle(idle_a), .timeout_err(terr_a), .frame_count(fc_a));

  serial_link_scheduler #(.NUM_REQ(4), .DATA_W(10), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_z (
    .clk(clk), .reset(reset), .link(if_z.slave),
    .link_idle(idle_z), .timeout_err(terr_z), .frame_count(fc_z));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (!idle_a && n < 300) begin tick(); n++; end
    chk(tag, 32'(idle_a), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(if_a.req_ready), 32'd0);
    chk({tag, "_data"},  32'(if_a.tx_data),   32'd0);
    chk({tag, "_id"},    32'(if_a.tx_id),     32'd0);
    chk({tag, "_start"}, 32'(if_a.tx_start),  32'd0);
    chk({tag, "_terr"},  32'(terr_a),         32'd0);
    chk({tag, "_fc"},    32'(fc_a),           32'd0);
    chk({tag, "_idle"},  32'(idle_a),         32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] exp_id [5];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;

    if_a.req_valid = '0; if_a.req_data = '0; if_a.tx_busy = 1'b0; if_a.tx_done = 1'b0;
    if_z.req_valid = '0; if_z.req_data = '0; if_z.tx_busy = 1'b0; if_z.tx_done = 1'b0;

    // Reset values
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Single requester
    if_a.req_valid = 4'b0010;
    if_a.req_data[19:10] = 10'h2A5;
    #1 chk("single_ready", 32'(if_a.req_ready), 32'b0010);
    tick();
    if_a.req_valid = '0;
    chk("single_ready_drop", 32'(if_a.req_ready), 32'd0);
    chk("single_data", 32'(if_a.tx_data), 32'h2A5);
    chk("single_id", 32'(if_a.tx_id), 32'd1);
    chk("single_start_early", 32'(if_a.tx_start), 32'd0);
    tick();
    chk("single_start", 32'(if_a.tx_start), 32'd1);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("single_start_width", 32'(if_a.tx_start), 32'd0);
    chk("single_fc", 32'(fc_a), 32'd1);
    n = 0;
    while (!idle_a && n < 200) begin n++; tick(); end
    chk("single_gap_len", 32'(n), 32'd100);

    // Busy hold (rr_ptr=2, only requester 0 valid)
    if_a.tx_busy = 1'b1;
    if_a.req_valid = 4'b0001;
    if_a.req_data[9:0] = 10'h155;
    #1 chk("busy_ready", 32'(if_a.req_ready), 32'b0001);
    tick();
    if_a.req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      chk("busy_hold_start", 32'(if_a.tx_start), 32'd0);
      tick();
    end
    if_a.tx_busy = 1'b0;
    chk("busy_fall_start", 32'(if_a.tx_start), 32'd0);
    tick();
    chk("busy_start", 32'(if_a.tx_start), 32'd1);
    chk("busy_data", 32'(if_a.tx_data), 32'h155);
    tick();
    chk("busy_start_width", 32'(if_a.tx_start), 32'd0);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("busy_fc", 32'(fc_a), 32'd2);
    wait_idle_a("busy_idle");

    // Timeout (rr_ptr=1, requester 2)
    if_a.req_valid = 4'b0100;
    if_a.req_data[29:20] = 10'h3C3;
    tick();
    if_a.req_valid = '0;
    chk("tmo_id", 32'(if_a.tx_id), 32'd2);
    tick();
    chk("tmo_start", 32'(if_a.tx_start), 32'd1);
    n = 0;
    while (!terr_a && n < 200) begin tick(); n++; end
    chk("tmo_delay", 32'(n), 32'd64);
    chk("tmo_fc", 32'(fc_a), 32'd2);
    tick();
    chk("tmo_pulse_width", 32'(terr_a), 32'd0);
    wait_idle_a("tmo_idle");

    // tx_done on the last timeout cycle (requester 3)
    if_a.req_valid = 4'b1000;
    if_a.req_data[39:30] = 10'h0F0;
    tick();
    if_a.req_valid = '0;
    tick();
    chk("coll_start", 32'(if_a.tx_start), 32'd1);
    for (int i = 0; i < 63; i++) tick();
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("coll_terr", 32'(terr_a), 32'd0);
    chk("coll_fc", 32'(fc_a), 32'd3);
    tick();
    chk("coll_terr_late", 32'(terr_a), 32'd0);

    // Round robin from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) if_a.req_data[i*10 +: 10] = 10'(10'h100 + i);
    if_a.req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      n = 0;
      while (!if_a.tx_start && n < 400) begin tick(); n++; end
      chk("rr_start_seen", 32'(if_a.tx_start), 32'd1);
      chk("rr_id", 32'(if_a.tx_id), 32'(exp_id[f]));
      chk("rr_data", 32'(if_a.tx_data), 32'h100 + 32'(exp_id[f]));
      for (int i = 0; i < 5; i++) tick();
      if_a.tx_done = 1'b1;
      tick();
      if_a.tx_done = 1'b0;
    end
    chk("rr_fc", 32'(fc_a), 32'd5);
    if_a.req_valid = '0;
    wait_idle_a("rr_idle");

    // Reset during WAIT_DONE with requester 2 granted (rr_ptr=1)
    if_a.req_valid = 4'b0100;
    #1 chk("mid_ready", 32'(if_a.req_ready), 32'b0100);
    tick();
    if_a.req_valid = '0;
    tick(); tick(); tick();
    chk("mid_id", 32'(if_a.tx_id), 32'd2);
    #3 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    tick();
    reset = 1'b0;
    if_a.req_data[19:10] = 10'h1AB;
    if_a.req_data[29:20] = 10'h2CD;
    if_a.req_valid = 4'b0110;
    #1 chk("post_rst_ready", 32'(if_a.req_ready), 32'b0010);
    tick();
    if_a.req_valid = '0;
    chk("post_rst_id", 32'(if_a.tx_id), 32'd1);
    chk("post_rst_data", 32'(if_a.tx_data), 32'h1AB);

    // Zero gap and frame counter wrap on the second instance
    force dut_z.frame_count = 16'hFFFE;
    tick();
    release dut_z.frame_count;
    if_z.req_data[9:0] = 10'h077;
    if_z.req_valid = 4'b0001;
    tick();
    tick();
    chk("zg_start", 32'(if_z.tx_start), 32'd1);
    if_z.tx_done = 1'b1;
    tick();
    if_z.tx_done = 1'b0;
    chk("zg_fc_ffff", 32'(fc_z), 32'hFFFF);
    chk("zg_idle_no_gap", 32'(idle_z), 32'd1);
    chk("zg_ready_no_gap", 32'(if_z.req_ready), 32'b0001);
    tick();
    tick();
    chk("zg_start_spacing", 32'(if_z.tx_start), 32'd1);
    if_z.tx_done = 1'b1;
    tick();
    if_z.tx_done = 1'b0;
    if_z.req_valid = '0;
    chk("zg_fc_wrap", 32'(fc_z), 32'h0000);
    chk("zg_terr", 32'(terr_z), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
